// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for the NPC simulation top.
// Sequences the DUT reset (PRE -> ASSERT -> RUN), counts RUN cycles and
// retired instructions, and decides end of run. A run ends when every hart has
// committed an end, when commits stop for too long, or when the cycle budget
// runs out. Results stay frozen in DONE until a soft restart or a controller
// reset.
module sim_run_ctrl #(
  parameter int unsigned NUM_HARTS        = 1,
  parameter int unsigned PRE_RESET_CYCLES = 10,
  parameter int unsigned RESET_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 5000000,
  parameter int unsigned IDLE_LIMIT       = 0,
  parameter int unsigned CNT_W            = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_HARTS-1:0]    commit_valid,
  input  logic [NUM_HARTS-1:0]    commit_isEnd,
  input  logic [32*NUM_HARTS-1:0] commit_code,
  input  logic                    soft_restart,
  output logic                    dut_reset,
  output logic                    running,
  output logic                    done,
  output logic                    pass,
  output logic                    fail_timeout,
  output logic                    fail_hang,
  output logic [31:0]             exit_code,
  output logic [NUM_HARTS-1:0]    ended_mask,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instr_count
);

  // Width that holds a popcount of NUM_HARTS bits (never zero-width).
  localparam int unsigned POP_W = $clog2(NUM_HARTS + 1) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  // Phase counter end values for the two reset-sequencing states.
  localparam logic [31:0] PRE_LAST = 32'(PRE_RESET_CYCLES - 1);
  localparam logic [31:0] RST_LAST = 32'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PRE    = 2'd0,
    ST_ASSERT = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          phase_q, phase_d;
  logic [CNT_W-1:0]     cycle_q, cycle_d;
  logic [CNT_W-1:0]     instr_q, instr_d;
  logic [CNT_W-1:0]     idle_q, idle_d;
  logic [NUM_HARTS-1:0] ended_q, ended_d;
  logic [31:0]          exit_q, exit_d;
  logic                 nonzero_q, nonzero_d;
  logic                 pass_q, pass_d;
  logic                 fail_timeout_q, fail_timeout_d;
  logic                 fail_hang_q, fail_hang_d;
  logic                 dut_reset_q, dut_reset_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;

  // Per-hart decode of the commit channels.
  logic [NUM_HARTS-1:0] new_end;
  logic [NUM_HARTS-1:0] new_end_nz;

  // An end only counts the first time a hart reports it; the code of a
  // repeated end from an already-ended hart is never considered.
  generate
    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      assign new_end[gi]    = commit_valid[gi] & commit_isEnd[gi] & ~ended_q[gi];
      assign new_end_nz[gi] = new_end[gi] & (commit_code[32*gi +: 32] != 32'd0);
    end
  endgenerate

  logic [POP_W-1:0] commit_pop;
  logic [31:0]      first_nz_code;

  // Popcount of commits this cycle, and the code of the lowest-indexed hart
  // that ends with a nonzero code (scanning downward so the lowest wins).
  always_comb begin
    commit_pop    = '0;
    first_nz_code = 32'd0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      commit_pop = commit_pop + POP_W'(commit_valid[i]);
    end
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (new_end_nz[i]) begin
        first_nz_code = commit_code[32*i +: 32];
      end
    end
  end

  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] idle_inc;
  logic [SUM_W-1:0] instr_sum;
  logic [CNT_W-1:0] instr_inc;

  // Saturating counter arithmetic: counters stick at all-ones instead of wrapping.
  always_comb begin
    cycle_inc = (cycle_q == {CNT_W{1'b1}}) ? cycle_q : cycle_q + CNT_W'(1);
    idle_inc  = (idle_q  == {CNT_W{1'b1}}) ? idle_q  : idle_q  + CNT_W'(1);
    instr_sum = {1'b0, instr_q} + SUM_W'(commit_pop);
    instr_inc = instr_sum[CNT_W] ? {CNT_W{1'b1}} : instr_sum[CNT_W-1:0];
  end

  // Next-state and result logic. Exit checks in RUN look at the updated
  // counters so that done rises on the edge after the deciding cycle.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cycle_d        = cycle_q;
    instr_d        = instr_q;
    idle_d         = idle_q;
    ended_d        = ended_q;
    exit_d         = exit_q;
    nonzero_d      = nonzero_q;
    pass_d         = pass_q;
    fail_timeout_d = fail_timeout_q;
    fail_hang_d    = fail_hang_q;

    case (state_q)
      ST_PRE: begin
        if (phase_q == PRE_LAST) begin
          state_d = ST_ASSERT;
          phase_d = 32'd0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end

      ST_ASSERT: begin
        if (phase_q == RST_LAST) begin
          // Fresh run: every per-run statistic starts from zero.
          state_d        = ST_RUN;
          phase_d        = 32'd0;
          cycle_d        = '0;
          instr_d        = '0;
          idle_d         = '0;
          ended_d        = '0;
          exit_d         = 32'd0;
          nonzero_d      = 1'b0;
          pass_d         = 1'b0;
          fail_timeout_d = 1'b0;
          fail_hang_d    = 1'b0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end

      ST_RUN: begin
        cycle_d = cycle_inc;
        instr_d = instr_inc;
        idle_d  = (|commit_valid) ? '0 : idle_inc;
        ended_d = ended_q | new_end;
        if (!nonzero_q && (|new_end_nz)) begin
          nonzero_d = 1'b1;
          exit_d    = first_nz_code;
        end

        if (&ended_d) begin
          state_d = ST_DONE;
          pass_d  = ~nonzero_d;
        end else if ((IDLE_LIMIT != 0) && (64'(idle_d) >= 64'(IDLE_LIMIT))) begin
          state_d     = ST_DONE;
          fail_hang_d = 1'b1;
        end else if (64'(cycle_d) >= 64'(TIMEOUT_CYCLES)) begin
          state_d        = ST_DONE;
          fail_timeout_d = 1'b1;
        end
      end

      ST_DONE: begin
        // Results are frozen; only a restart request leaves this state.
        if (soft_restart) begin
          state_d        = ST_PRE;
          phase_d        = 32'd0;
          cycle_d        = '0;
          instr_d        = '0;
          idle_d         = '0;
          ended_d        = '0;
          exit_d         = 32'd0;
          nonzero_d      = 1'b0;
          pass_d         = 1'b0;
          fail_timeout_d = 1'b0;
          fail_hang_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_PRE;
        phase_d = 32'd0;
      end
    endcase

    // Status outputs follow the state being entered so they are registered
    // and line up with the state register.
    dut_reset_d = (state_d == ST_ASSERT);
    running_d   = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  // State and result registers; the controller reset returns to PRE at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_PRE;
      phase_q        <= 32'd0;
      cycle_q        <= '0;
      instr_q        <= '0;
      idle_q         <= '0;
      ended_q        <= '0;
      exit_q         <= 32'd0;
      nonzero_q      <= 1'b0;
      pass_q         <= 1'b0;
      fail_timeout_q <= 1'b0;
      fail_hang_q    <= 1'b0;
      dut_reset_q    <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cycle_q        <= cycle_d;
      instr_q        <= instr_d;
      idle_q         <= idle_d;
      ended_q        <= ended_d;
      exit_q         <= exit_d;
      nonzero_q      <= nonzero_d;
      pass_q         <= pass_d;
      fail_timeout_q <= fail_timeout_d;
      fail_hang_q    <= fail_hang_d;
      dut_reset_q    <= dut_reset_d;
      running_q      <= running_d;
      done_q         <= done_d;
    end
  end

  assign dut_reset    = dut_reset_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_timeout = fail_timeout_q;
  assign fail_hang    = fail_hang_q;
  assign exit_code    = exit_q;
  assign ended_mask   = ended_q;
  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;

endmodule
